// File: rtl/aes_key_sched.sv
// AES key-schedule engine for 128/192/256-bit keys: expands one word per cycle
// into a round-key store and serves whole round keys in forward or reverse order.
`timescale 1ns/1ps
module aes_key_sched #(
    parameter int MAX_KEY_BITS = 256,
    parameter int OUT_REG      = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   key_len,
    input  logic [255:0] key_in,
    output logic         busy,
    output logic         key_valid,
    output logic         err,
    input  logic         rk_rd,
    input  logic [3:0]   rk_idx,
    input  logic         dec,
    output logic [127:0] rk_out,
    output logic         rk_out_valid
);

    localparam int DEPTH = (MAX_KEY_BITS >= 256) ? 60 : (MAX_KEY_BITS >= 192) ? 52 : 44;

    typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

    state_t       state_q, state_d;
    logic [1:0]   klen_q, klen_d;
    logic [5:0]   i_q, i_d;
    logic [2:0]   cnt_q, cnt_d;
    logic [7:0]   rcon_q, rcon_d;
    logic         err_q, err_d;
    logic [31:0]  store_q [DEPTH];

    logic [3:0]   nk, nr;
    logic [5:0]   ntot;
    logic         len_ok, can_start, accept, key_wr, exp_wr;
    logic [31:0]  temp, prev, sw_in, sw_out, temp_n, new_word;
    logic         rd_ok;
    logic [3:0]   eff;
    logic [5:0]   base;
    logic [127:0] rd_data;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254) followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq, inv;
        sq  = x;
        inv = 8'h01;
        for (int k = 0; k < 7; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [3:0] nk_of(input logic [1:0] kl);
        return (kl == 2'b00) ? 4'd4 : (kl == 2'b01) ? 4'd6 : 4'd8;
    endfunction

    always_comb begin
        nk   = nk_of(klen_q);
        nr   = nk + 4'd6;
        ntot = {nr + 4'd1, 2'b00};
        unique case (key_len)
            2'b00:   len_ok = 1'b1;
            2'b01:   len_ok = (MAX_KEY_BITS >= 192);
            2'b10:   len_ok = (MAX_KEY_BITS >= 256);
            default: len_ok = 1'b0;
        endcase
        can_start = (state_q != EXPAND);
        accept    = start && can_start && len_ok;
        err_d     = start && can_start && !len_ok;
    end

    // One new word per cycle: w[i] = w[i-Nk] ^ f(w[i-1]).
    always_comb begin
        temp   = store_q[i_q - 6'd1];
        prev   = store_q[i_q - {2'b00, nk}];
        sw_in  = (cnt_q == 3'd0) ? {temp[23:0], temp[31:24]} : temp;
        sw_out = sub_word(sw_in);
        if (cnt_q == 3'd0)
            temp_n = sw_out ^ {rcon_q, 24'h0};
        else if (nk == 4'd8 && cnt_q == 3'd4)
            temp_n = sw_out;
        else
            temp_n = temp;
        new_word = prev ^ temp_n;
    end

    always_comb begin
        state_d = state_q;
        klen_d  = klen_q;
        i_d     = i_q;
        cnt_d   = cnt_q;
        rcon_d  = rcon_q;
        key_wr  = 1'b0;
        exp_wr  = 1'b0;
        unique case (state_q)
            IDLE, READY: begin
                if (accept) begin
                    state_d = EXPAND;
                    klen_d  = key_len;
                    i_d     = {2'b00, nk_of(key_len)};
                    cnt_d   = 3'd0;
                    rcon_d  = 8'h01;
                    key_wr  = 1'b1;
                end
            end
            EXPAND: begin
                exp_wr = 1'b1;
                i_d    = i_q + 6'd1;
                cnt_d  = ({1'b0, cnt_q} == nk - 4'd1) ? 3'd0 : cnt_q + 3'd1;
                if (cnt_q == 3'd0) rcon_d = xtime(rcon_q);
                if (i_q == ntot - 6'd1) state_d = READY;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            klen_q  <= 2'b00;
            i_q     <= 6'd0;
            cnt_q   <= 3'd0;
            rcon_q  <= 8'h01;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            klen_q  <= klen_d;
            i_q     <= i_d;
            cnt_q   <= cnt_d;
            rcon_q  <= rcon_d;
            err_q   <= err_d;
        end
    end

    // Words beyond Nk written on accept are overwritten before key_valid rises.
    always_ff @(posedge clk) begin
        if (key_wr) begin
            for (int k = 0; k < 8; k++) store_q[k] <= key_in[255 - 32*k -: 32];
        end else if (exp_wr) begin
            store_q[i_q] <= new_word;
        end
    end

    assign busy      = (state_q == EXPAND);
    assign key_valid = (state_q == READY);
    assign err       = err_q;

    // Index is forced to 0 when the read is invalid so the store is never over-indexed.
    always_comb begin
        rd_ok   = key_valid && (rk_idx <= nr);
        eff     = rd_ok ? (dec ? nr - rk_idx : rk_idx) : 4'd0;
        base    = {eff, 2'b00};
        rd_data = rd_ok ? {store_q[base], store_q[base + 6'd1],
                           store_q[base + 6'd2], store_q[base + 6'd3]} : 128'h0;
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [127:0] rk_out_q, rk_out_d;
            logic         rk_out_valid_q, rk_out_valid_d;

            always_comb begin
                rk_out_d       = rk_rd ? rd_data : rk_out_q;
                rk_out_valid_d = rk_rd && rd_ok;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rk_out_q       <= 128'h0;
                    rk_out_valid_q <= 1'b0;
                end else begin
                    rk_out_q       <= rk_out_d;
                    rk_out_valid_q <= rk_out_valid_d;
                end
            end

            assign rk_out       = rk_out_q;
            assign rk_out_valid = rk_out_valid_q;
        end else begin : g_out_comb
            assign rk_out       = rd_data;
            assign rk_out_valid = rk_rd && rd_ok;
        end
    endgenerate

endmodule

// File: tb/tb_aes_key_sched.sv
// Bench for aes_key_sched: known-answer table, random keys against a FIPS-style
// expansion model, and hand sequences for reject, mid-expansion start and reset.
`timescale 1ns/1ps
module tb_aes_key_sched;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   key_len = 2'b00;
    logic [255:0] key_in = '0;
    logic         rk_rd = 1'b0;
    logic [3:0]   rk_idx = 4'd0;
    logic         dec = 1'b0;

    logic         busy, key_valid, err, rk_out_valid;
    logic [127:0] rk_out;
    logic         busy_s, key_valid_s, err_s, rk_out_valid_s;
    logic [127:0] rk_out_s;

    always #5 clk = ~clk;

    aes_key_sched #(.MAX_KEY_BITS(256), .OUT_REG(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key_len(key_len), .key_in(key_in),
        .busy(busy), .key_valid(key_valid), .err(err), .rk_rd(rk_rd), .rk_idx(rk_idx),
        .dec(dec), .rk_out(rk_out), .rk_out_valid(rk_out_valid)
    );

    aes_key_sched #(.MAX_KEY_BITS(128), .OUT_REG(0)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .key_len(key_len), .key_in(key_in),
        .busy(busy_s), .key_valid(key_valid_s), .err(err_s), .rk_rd(rk_rd), .rk_idx(rk_idx),
        .dec(dec), .rk_out(rk_out_s), .rk_out_valid(rk_out_valid_s)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  sbox_tab [256];
    logic [2047:0] sbox_flat;
    logic [7:0]  rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                   8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    logic [31:0] mw [60];
    int          m_nk = 4;

    typedef struct {
        logic [1:0]   kl;
        logic [255:0] key;
        int           lat;
        int           idx;
        logic         d;
        logic [127:0] rk;
        logic         v;
    } vec_t;
    vec_t vecs [8];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_sub(input logic [31:0] w);
        return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
    endfunction

    function automatic void model_expand(input logic [255:0] key, input int nk);
        int tot;
        logic [31:0] t;
        tot  = 4 * (nk + 7);
        m_nk = nk;
        for (int i = 0; i < nk; i++) mw[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < tot; i++) begin
            t = mw[i-1];
            if (i % nk == 0)
                t = m_sub({t[23:0], t[31:24]}) ^ {rcon_tab[i/nk - 1], 24'h0};
            else if (nk == 8 && i % nk == 4)
                t = m_sub(t);
            mw[i] = mw[i-nk] ^ t;
        end
    endfunction

    function automatic logic [127:0] model_rk(input int idx, input logic d);
        int nr, e;
        nr = m_nk + 6;
        if (idx > nr) return '0;
        e = d ? nr - idx : idx;
        return {mw[4*e], mw[4*e+1], mw[4*e+2], mw[4*e+3]};
    endfunction

    task automatic start_pulse(input logic [1:0] kl, input logic [255:0] k);
        @(negedge clk);
        key_len = kl;
        key_in  = k;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (n < 200 && !key_valid) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic do_read(input int idx, input logic d, output logic [127:0] r, output logic v,
                           output logic [127:0] r_s, output logic v_s);
        @(negedge clk);
        rk_rd  = 1'b1;
        rk_idx = 4'(idx);
        dec    = d;
        #1;
        r_s = rk_out_s;
        v_s = rk_out_valid_s;
        @(posedge clk);
        #1;
        rk_rd = 1'b0;
        r = rk_out;
        v = rk_out_valid;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, nk, idx;
        logic d;
        logic [1:0] kl;
        logic [255:0] k;
        logic [127:0] r, r_s;
        logic v, v_s;

        sbox_flat = {
            128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
            128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
            128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
            128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
            128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
            128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
            128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
            128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
        for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_flat[2047 - 8*i -: 8];

        vecs[0] = '{2'b00, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 40, 10, 1'b0,
                    128'h13111d7fe3944a17f307a78b4d2b30c5, 1'b1};
        vecs[1] = '{2'b00, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 40, 0, 1'b1,
                    128'h13111d7fe3944a17f307a78b4d2b30c5, 1'b1};
        vecs[2] = '{2'b00, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 40, 10, 1'b0,
                    128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1};
        vecs[3] = '{2'b00, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 40, 0, 1'b0,
                    128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1};
        vecs[4] = '{2'b01, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 46, 12, 1'b0,
                    128'ha4970a331a78dc09c418c271e3a41d5d, 1'b1};
        vecs[5] = '{2'b01, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 46, 13, 1'b0,
                    128'h0, 1'b0};
        vecs[6] = '{2'b10, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 52, 0, 1'b1,
                    128'h24fc79ccbf0979e9371ac23c6d68de36, 1'b1};
        vecs[7] = '{2'b10, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 52, 14, 1'b1,
                    128'h000102030405060708090a0b0c0d0e0f, 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_key_valid", 128'(key_valid), 128'(0));
        check("rst_err", 128'(err), 128'(0));
        check("rst_rk_out_valid", 128'(rk_out_valid), 128'(0));
        check("rst_rk_out", rk_out, 128'h0);
        check("rst_key_valid_s", 128'(key_valid_s), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Known-answer table
        for (int t = 0; t < 8; t++) begin
            start_pulse(vecs[t].kl, vecs[t].key);
            check($sformatf("vec%0d_err", t), 128'(err), 128'(0));
            check($sformatf("vec%0d_busy", t), 128'(busy), 128'(1));
            wait_valid(n);
            check($sformatf("vec%0d_latency", t), 128'(n), 128'(vecs[t].lat));
            do_read(vecs[t].idx, vecs[t].d, r, v, r_s, v_s);
            $display("vec%0d kl=%0d idx=%0d dec=%0d rk=%h v=%0d", t, vecs[t].kl, vecs[t].idx, vecs[t].d, r, v);
            check($sformatf("vec%0d_rk", t), r, vecs[t].rk);
            check($sformatf("vec%0d_valid", t), 128'(v), 128'(vecs[t].v));
            if (vecs[t].kl == 2'b00) begin
                check($sformatf("vec%0d_rk_comb", t), r_s, vecs[t].rk);
                check($sformatf("vec%0d_valid_comb", t), 128'(v_s), 128'(vecs[t].v));
            end
        end

        // Full forward and reverse sweep of the FIPS-197 App. A key
        k = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        model_expand(k, 4);
        start_pulse(2'b00, k);
        wait_valid(n);
        check("sweep_latency", 128'(n), 128'(40));
        for (int dd = 0; dd < 2; dd++) begin
            for (int i = 0; i <= 10; i++) begin
                do_read(i, dd[0], r, v, r_s, v_s);
                $display("sweep dec=%0d idx=%0d rk=%h", dd, i, r);
                check($sformatf("sweep_d%0d_i%0d", dd, i), r, model_rk(i, dd[0]));
                check($sformatf("sweep_comb_d%0d_i%0d", dd, i), r_s, model_rk(i, dd[0]));
            end
        end

        // Random keys and random reads, including out-of-range indices
        for (int it = 0; it < 8; it++) begin
            kl = 2'($urandom_range(0, 2));
            nk = 4 + 2 * int'(kl);
            k  = {$urandom(), $urandom(), $urandom(), $urandom(),
                  $urandom(), $urandom(), $urandom(), $urandom()};
            model_expand(k, nk);
            start_pulse(kl, k);
            wait_valid(n);
            check($sformatf("rand%0d_latency", it), 128'(n), 128'(4 * (nk + 7) - nk));
            for (int j = 0; j < 6; j++) begin
                idx = int'($urandom_range(0, 15));
                d   = 1'($urandom_range(0, 1));
                do_read(idx, d, r, v, r_s, v_s);
                $display("rand%0d nk=%0d idx=%0d dec=%0d rk=%h v=%0d", it, nk, idx, d, r, v);
                check($sformatf("rand%0d_rk%0d", it, j), r, model_rk(idx, d));
                check($sformatf("rand%0d_v%0d", it, j), 128'(v), 128'(idx <= nk + 6));
            end
        end

        // Illegal key_len: one-cycle err, schedule untouched
        start_pulse(2'b11, '1);
        $display("reject key_len=3 err=%0d key_valid=%0d busy=%0d", err, key_valid, busy);
        check("rej_err", 128'(err), 128'(1));
        check("rej_key_valid", 128'(key_valid), 128'(1));
        check("rej_busy", 128'(busy), 128'(0));
        @(posedge clk);
        #1;
        check("rej_err_drop", 128'(err), 128'(0));
        do_read(0, 1'b1, r, v, r_s, v_s);
        check("rej_rk_kept", r, model_rk(0, 1'b1));

        // Start mid-EXPAND ignored; reads during EXPAND are invalid
        k = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
        model_expand(k, 4);
        start_pulse(2'b00, k);
        repeat (4) @(posedge clk);
        #1;
        do_read(3, 1'b0, r, v, r_s, v_s);
        check("exp_read_rk", r, 128'h0);
        check("exp_read_valid", 128'(v), 128'(0));
        start_pulse(2'b00, {128'hffeeddccbbaa99887766554433221100, 128'h0});
        check("mid_start_err", 128'(err), 128'(0));
        check("mid_start_busy", 128'(busy), 128'(1));
        wait_valid(n);
        $display("mid-expand start: completion after %0d cycles", n + 6);
        check("mid_start_latency", 128'(n + 6), 128'(40));
        do_read(10, 1'b0, r, v, r_s, v_s);
        check("mid_start_rk", r, 128'h13111d7fe3944a17f307a78b4d2b30c5);

        // Re-key from READY: key_valid drops on the accept edge
        k = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        model_expand(k, 4);
        start_pulse(2'b00, k);
        check("rekey_key_valid", 128'(key_valid), 128'(0));
        do_read(0, 1'b0, r, v, r_s, v_s);
        check("rekey_read_valid", 128'(v), 128'(0));
        check("rekey_read_comb_valid", 128'(v_s), 128'(0));
        wait_valid(n);
        check("rekey_latency", 128'(n + 1), 128'(40));

        // 256-bit key on a 128-bit-only instance is rejected there
        start_pulse(2'b10, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
        $display("key_len=2 on max128: err_s=%0d key_valid_s=%0d err=%0d", err_s, key_valid_s, err);
        check("max128_err", 128'(err_s), 128'(1));
        check("max128_key_valid", 128'(key_valid_s), 128'(1));
        check("max128_busy", 128'(busy_s), 128'(0));
        check("max256_err", 128'(err), 128'(0));

        // Reset during AES-256 expansion, then a clean AES-128 run
        repeat (19) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        $display("reset mid-expand: busy=%0d key_valid=%0d rk_out=%h", busy, key_valid, rk_out);
        check("mid_rst_busy", 128'(busy), 128'(0));
        check("mid_rst_key_valid", 128'(key_valid), 128'(0));
        check("mid_rst_rk_out", rk_out, 128'h0);
        check("mid_rst_rk_out_valid", 128'(rk_out_valid), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        do_read(0, 1'b0, r, v, r_s, v_s);
        check("post_rst_read_valid", 128'(v), 128'(0));
        check("post_rst_read_rk", r, 128'h0);
        start_pulse(2'b00, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
        wait_valid(n);
        check("post_rst_latency", 128'(n), 128'(40));
        do_read(10, 1'b0, r, v, r_s, v_s);
        check("post_rst_rk10", r, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        do_read(0, 1'b1, r, v, r_s, v_s);
        check("post_rst_dec0", r, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        check("post_rst_dec0_comb", r_s, 128'h13111d7fe3944a17f307a78b4d2b30c5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
